aes_host_sequencer: RTL and testbench
=====================================

Name: aes_host_sequencer

Overview:
Bus-side sequencer between the 32-bit host bus and the AES-128 core, directly downstream of the host interface. It packs host word writes into 128-bit message and key blocks. When both blocks are complete it launches the core with a one-cycle start pulse, captures the 128-bit ciphertext on done, and serves it back as four sequential 32-bit reads. It also provides busy and sticky timeout-error status.

Parameters:
WORD_W, 32, host bus word width
BLOCK_W, 128, AES block/key width
NWORDS, BLOCK_W/WORD_W (4), words per block
TIMEOUT, 64, max cycles from core_start to core_done before error

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
cs  in  1  bus transfer strobe; one word per cycle while high
rw  in  1  1 = write, 0 = read
adress  in  1  write target: 0 = message, 1 = key; ignored on reads
wdata  in  [0:WORD_W-1]  write data
rdata  out  [0:WORD_W-1]  read data
rvalid  out  1  read data valid, one cycle after read strobe
busy  out  1  high while core running
err  out  1  sticky timeout flag
message  out  [0:BLOCK_W-1]  packed plaintext to core
key  out  [0:BLOCK_W-1]  packed key to core
core_start  out  1  one-cycle launch pulse
core_done  in  1  core completion pulse
crypte  in  [0:BLOCK_W-1]  ciphertext from core, valid with core_done

Behaviour:
- Reset (asynchronous assert, synchronous deassert at the clock):
  - Outputs: message, key, rdata = 0; rvalid, busy, err, core_start = 0.
  - Internal: msg_cnt, key_cnt, rd_cnt, timer = 0; state = LOAD.
  - Reset mid-RUN or mid-UNLOAD aborts the operation; a later core_done is ignored in LOAD.
- Big-endian packing: word i (0..3) occupies bits [32*i : 32*i+31]. Word 0 is bits [0:31], the first word written.
- States: LOAD, RUN, UNLOAD.
- LOAD:
  - cs&rw&adress=0 writes message word msg_cnt; msg_cnt increments to 4, then holds.
  - cs&rw&adress=1 does the same for key using key_cnt.
  - A write to a block whose cnt==4 starts a new block: word 0 is written, cnt=1.
  - When registered msg_cnt==4 and key_cnt==4, the next edge moves to RUN:
    - core_start=1 for exactly that one cycle; busy=1; timer=0.
    - Any write in that transition cycle is dropped.
- RUN:
  - All writes are ignored.
  - timer increments each cycle.
  - core_done=1 → crypte captured into the output buffer; err cleared; go UNLOAD; rd_cnt=0; busy=0.
  - If timer reaches TIMEOUT-1 without done → err=1; msg_cnt=0; go LOAD; busy=0.
  - core_done and timeout on the same cycle → done wins.
- UNLOAD:
  - Writes are ignored.
  - cs&!rw → next cycle rdata = buffer word rd_cnt, rvalid=1; rd_cnt increments.
  - After the 4th read is issued: go LOAD, msg_cnt=0. key_cnt stays 4, so the key persists across blocks.
- Reads outside UNLOAD: next cycle rdata=0, rvalid=1, so the bus never stalls.
- rvalid is 0 in every cycle with no read strobe in the previous cycle; rdata holds its last value.
- message and key outputs are registered and update the edge after each accepted write. They are stable throughout RUN.
- core_done outside RUN is ignored.

Decomposition:
- Package aes_pkg:
  - Constants WORD_W, BLOCK_W, NWORDS.
  - ADDR_MSG=0, ADDR_KEY=1.
  - Enum seq_state_t {LOAD, RUN, UNLOAD}.
- Sub-module aes_word_packer: a 32→128 register with a 0..4 saturating/restarting word counter and a full flag. Instantiated twice (message, key); the sequencer owns the FSM, timer and read buffer.

Test Plan:
- Key write 00010203, 04050607, 08090a0b, 0c0d0e0f; then message 00112233, 44556677, 8899aabb, ccddeeff → key=000102…0f and message=00112233…ccddeeff. core_start is high exactly one cycle, on the edge after the 4th message word, and busy=1.
- During RUN, drive crypte=69c4e0d86a7b0430d8cdb78070b4c55a with core_done=1 → four reads return 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a, each with rvalid=1 one cycle later; state returns to LOAD.
- Second block with the key unchanged: write 4 message words only → core_start fires again; key output unchanged.
- Withhold core_done for 64 cycles after start → err=1 and busy=0 at cycle 64; a 4-word write then a successful done clears err.
- Write 5 message words with the key absent → msg_cnt=1 and message bits [0:31] hold the 5th word; bits [32:127] are unchanged from the previous writes.
- Assert reset low mid-RUN → all outputs 0 asynchronously, state LOAD; a core_done after release is ignored; read returns 00000000 with rvalid=1.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared definitions for the AES host sequencer slice.
// Contents:
//   WORD_W / BLOCK_W / NWORDS : host word, AES block and words-per-block sizes
//   ADDR_MSG / ADDR_KEY       : write-target select values on the adress line
//   seq_state_t               : sequencer FSM states
package aes_pkg;

  localparam int WORD_W  = 32;
  localparam int BLOCK_W = 128;
  localparam int NWORDS  = BLOCK_W / WORD_W;

  localparam logic ADDR_MSG = 1'b0;
  localparam logic ADDR_KEY = 1'b1;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    RUN    = 2'd1,
    UNLOAD = 2'd2
  } seq_state_t;

endpackage

// File: rtl/aes_host_sequencer_if.sv
// Host bus bundle between the host interface and the AES sequencer.
// Signals:
//   cs, rw, adress, wdata : transfer strobe, direction, write target, write data
//   rdata, rvalid         : read data and its one-cycle-late valid
//   busy, err             : core running / sticky timeout status
// Modports: master (host side), slave (sequencer side).
interface aes_host_sequencer_if;
  import aes_pkg::*;

  logic                cs;
  logic                rw;
  logic                adress;
  logic [0:WORD_W-1]   wdata;
  logic [0:WORD_W-1]   rdata;
  logic                rvalid;
  logic                busy;
  logic                err;

  modport master (
    output cs, rw, adress, wdata,
    input  rdata, rvalid, busy, err
  );

  modport slave (
    input  cs, rw, adress, wdata,
    output rdata, rvalid, busy, err
  );

endinterface

// File: rtl/aes_word_packer.sv
// Packs 32-bit host words into a 128-bit big-endian block.
// Word i lands in bits [32*i : 32*i+31]; word 0 is the first word written.
// The word counter saturates at NWORDS (block full); a further write restarts
// the block at word 0 without clearing the remaining words.
// Ports:
//   clk, reset : clock, asynchronous active-low reset
//   i_wr       : accept i_wdata this cycle
//   i_clr      : drop the counter to 0 (block contents are kept)
//   i_wdata    : host word
//   o_block    : packed block (registered)
//   o_full     : all NWORDS words present
module aes_word_packer
  import aes_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               i_wr,
  input  logic               i_clr,
  input  logic [0:WORD_W-1]  i_wdata,
  output logic [0:BLOCK_W-1] o_block,
  output logic               o_full
);

  localparam logic [2:0] CNT_FULL = 3'(NWORDS);

  logic [0:BLOCK_W-1] r_block;
  logic [2:0]         r_cnt;
  logic [2:0]         w_idx;

  // A write to a full block restarts it at word 0.
  assign w_idx = (r_cnt == CNT_FULL) ? 3'd0 : r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_block <= '0;
      r_cnt   <= '0;
    end else if (i_wr) begin
      for (int i = 0; i < NWORDS; i++) begin
        if (w_idx == 3'(i)) r_block[i*WORD_W +: WORD_W] <= i_wdata;
      end
      r_cnt <= w_idx + 3'd1;
    end else if (i_clr) begin
      r_cnt <= '0;
    end
  end

  assign o_block = r_block;
  assign o_full  = (r_cnt == CNT_FULL);

endmodule

// File: rtl/aes_host_sequencer.sv
// Bus-side sequencer between the 32-bit host bus and an AES-128 core.
// Host writes are packed into message and key blocks; once both are full the
// core is launched with a one-cycle core_start, the ciphertext is captured on
// core_done and handed back as four sequential 32-bit reads. A core that does
// not answer within TIMEOUT cycles sets the sticky err flag and the sequencer
// returns to loading (message must be rewritten, key is kept).
// Ports:
//   clk, reset  : clock, asynchronous active-low reset
//   bus         : host bus (slave modport)
//   message,key : packed blocks to the core (registered)
//   core_start  : one-cycle launch pulse
//   core_done   : core completion pulse, crypte valid with it
//   crypte      : ciphertext from the core
module aes_host_sequencer
  import aes_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  aes_host_sequencer_if.slave  bus,
  output logic [0:BLOCK_W-1]   message,
  output logic [0:BLOCK_W-1]   key,
  output logic                 core_start,
  input  logic                 core_done,
  input  logic [0:BLOCK_W-1]   crypte
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam int RW = $clog2(NWORDS);
  localparam logic [RW-1:0] RD_LAST = RW'(NWORDS - 1);

  seq_state_t         r_state;
  logic [TW-1:0]      r_timer;
  logic [RW-1:0]      r_rd_cnt;
  logic [0:BLOCK_W-1] r_buf;
  logic [0:WORD_W-1]  r_rdata;
  logic               r_rvalid;
  logic               r_busy;
  logic               r_err;
  logic               r_core_start;

  logic w_msg_full;
  logic w_key_full;
  logic w_launch;
  logic w_wr;
  logic w_rd;
  logic w_wr_msg;
  logic w_wr_key;
  logic w_timeout;
  logic w_unload_last;
  logic w_clr_msg;

  assign w_wr = bus.cs && bus.rw;
  assign w_rd = bus.cs && !bus.rw;

  // Launch is decided from the registered counters; a write arriving in the
  // launch cycle is dropped so the block handed to the core cannot change.
  assign w_launch = (r_state == LOAD) && w_msg_full && w_key_full;
  assign w_wr_msg = (r_state == LOAD) && !w_launch && w_wr && (bus.adress == ADDR_MSG);
  assign w_wr_key = (r_state == LOAD) && !w_launch && w_wr && (bus.adress == ADDR_KEY);

  // core_done on the timeout cycle wins over the timeout.
  assign w_timeout     = (r_state == RUN) && !core_done && (r_timer == TIMER_LAST);
  assign w_unload_last = (r_state == UNLOAD) && w_rd && (r_rd_cnt == RD_LAST);
  // Only the message is invalidated; the key persists across blocks.
  assign w_clr_msg     = w_timeout || w_unload_last;

  aes_word_packer u_msg (
    .clk     (clk),
    .reset   (reset),
    .i_wr    (w_wr_msg),
    .i_clr   (w_clr_msg),
    .i_wdata (bus.wdata),
    .o_block (message),
    .o_full  (w_msg_full)
  );

  aes_word_packer u_key (
    .clk     (clk),
    .reset   (reset),
    .i_wr    (w_wr_key),
    .i_clr   (1'b0),
    .i_wdata (bus.wdata),
    .o_block (key),
    .o_full  (w_key_full)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= LOAD;
      r_timer      <= '0;
      r_rd_cnt     <= '0;
      r_buf        <= '0;
      r_rdata      <= '0;
      r_rvalid     <= 1'b0;
      r_busy       <= 1'b0;
      r_err        <= 1'b0;
      r_core_start <= 1'b0;
    end else begin
      r_core_start <= 1'b0;
      // Every read strobe is answered next cycle so the bus never stalls;
      // outside UNLOAD the answer is zero.
      r_rvalid <= w_rd;
      if (w_rd && (r_state != UNLOAD)) r_rdata <= '0;

      case (r_state)
        LOAD: begin
          if (w_launch) begin
            r_state      <= RUN;
            r_core_start <= 1'b1;
            r_busy       <= 1'b1;
            r_timer      <= '0;
          end
        end
        RUN: begin
          r_timer <= r_timer + TW'(1);
          if (core_done) begin
            r_buf    <= crypte;
            r_err    <= 1'b0;
            r_rd_cnt <= '0;
            r_busy   <= 1'b0;
            r_state  <= UNLOAD;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= LOAD;
          end
        end
        UNLOAD: begin
          if (w_rd) begin
            for (int i = 0; i < NWORDS; i++) begin
              if (r_rd_cnt == RW'(i)) r_rdata <= r_buf[i*WORD_W +: WORD_W];
            end
            r_rd_cnt <= r_rd_cnt + RW'(1);
            if (r_rd_cnt == RD_LAST) r_state <= LOAD;
          end
        end
        default: r_state <= LOAD;
      endcase
    end
  end

  assign bus.rdata  = r_rdata;
  assign bus.rvalid = r_rvalid;
  assign bus.busy   = r_busy;
  assign bus.err    = r_err;
  assign core_start = r_core_start;

endmodule

// File: tb/tb_aes_host_sequencer.sv
module tb_aes_host_sequencer;
  import aes_pkg::*;

  logic               clk;
  logic               reset;
  logic [0:BLOCK_W-1] message;
  logic [0:BLOCK_W-1] key;
  logic               core_start;
  logic               core_done;
  logic [0:BLOCK_W-1] crypte;

  aes_host_sequencer_if bif ();

  aes_host_sequencer #(.TIMEOUT(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bif),
    .message    (message),
    .key        (key),
    .core_start (core_start),
    .core_done  (core_done),
    .crypte     (crypte)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic               adr;
    logic [31:0]        data;
    logic [0:BLOCK_W-1] exp_msg;
    logic [0:BLOCK_W-1] exp_key;
  } wvec_t;

  wvec_t tbl [8];

  localparam logic [0:BLOCK_W-1] KEY1 = 128'h00010203_04050607_08090a0b_0c0d0e0f;
  localparam logic [0:BLOCK_W-1] MSG1 = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [0:BLOCK_W-1] CT1  = 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a;
  localparam logic [0:BLOCK_W-1] MSG2 = 128'h11111111_22222222_33333333_44444444;
  localparam logic [0:BLOCK_W-1] CT3  = 128'hdeadbeef_cafebabe_01234567_89abcdef;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic adr, input logic [31:0] data);
    bif.cs = 1'b1; bif.rw = 1'b1; bif.adress = adr; bif.wdata = data;
    tick();
    bif.cs = 1'b0; bif.rw = 1'b0;
  endtask

  task automatic bus_read(input string name, input logic [31:0] exp);
    bif.cs = 1'b1; bif.rw = 1'b0;
    tick();
    bif.cs = 1'b0;
    chk({name, "_rvalid"}, 128'(bif.rvalid), 128'd1);
    chk({name, "_rdata"}, 128'(bif.rdata), 128'(exp));
  endtask

  task automatic read_block(input string name, input logic [0:BLOCK_W-1] ct);
    for (int i = 0; i < NWORDS; i++) bus_read(name, ct[i*32 +: 32]);
  endtask

  initial begin
    tbl[0] = '{1'b1, 32'h00010203, 128'h0, 128'h00010203_00000000_00000000_00000000};
    tbl[1] = '{1'b1, 32'h04050607, 128'h0, 128'h00010203_04050607_00000000_00000000};
    tbl[2] = '{1'b1, 32'h08090a0b, 128'h0, 128'h00010203_04050607_08090a0b_00000000};
    tbl[3] = '{1'b1, 32'h0c0d0e0f, 128'h0, KEY1};
    tbl[4] = '{1'b0, 32'h00112233, 128'h00112233_00000000_00000000_00000000, KEY1};
    tbl[5] = '{1'b0, 32'h44556677, 128'h00112233_44556677_00000000_00000000, KEY1};
    tbl[6] = '{1'b0, 32'h8899aabb, 128'h00112233_44556677_8899aabb_00000000, KEY1};
    tbl[7] = '{1'b0, 32'hccddeeff, MSG1, KEY1};

    reset = 1'b0; core_done = 1'b0; crypte = '0;
    bif.cs = 1'b0; bif.rw = 1'b0; bif.adress = 1'b0; bif.wdata = '0;
    tick(); tick();
    reset = 1'b1;
    tick();

    // Reset state
    chk("rst_message", message, 128'h0);
    chk("rst_key", key, 128'h0);
    chk("rst_flags", {bif.rvalid, bif.busy, bif.err, core_start}, 128'h0);
    chk("rst_rdata", 128'(bif.rdata), 128'h0);

    // Block 1: key then message, table driven
    for (int i = 0; i < 8; i++) begin
      bus_write(tbl[i].adr, tbl[i].data);
      chk($sformatf("tbl%0d_msg", i), tbl[i].exp_msg, message);
      chk($sformatf("tbl%0d_key", i), key, tbl[i].exp_key);
      chk($sformatf("tbl%0d_start", i), 128'(core_start), 128'h0);
    end
    tick();
    chk("b1_start_pulse", 128'(core_start), 128'd1);
    chk("b1_busy", 128'(bif.busy), 128'd1);
    core_done = 1'b1; crypte = CT1;
    tick();
    core_done = 1'b0; crypte = '0;
    chk("b1_start_single", 128'(core_start), 128'h0);
    chk("b1_busy_done", 128'(bif.busy), 128'h0);
    read_block("b1_rd", CT1);
    tick();
    chk("b1_rvalid_idle", 128'(bif.rvalid), 128'h0);
    chk("b1_rdata_hold", 128'(bif.rdata), 128'h70b4c55a);
    bus_read("b1_load_rd", 32'h0);

    // Block 2: message only, write in launch cycle and in RUN dropped, then timeout
    for (int i = 0; i < NWORDS; i++) bus_write(ADDR_MSG, MSG2[i*32 +: 32]);
    chk("b2_message", message, MSG2);
    bus_write(ADDR_MSG, 32'h55555555);
    chk("b2_start", 128'(core_start), 128'd1);
    chk("b2_launch_drop", message, MSG2);
    chk("b2_key_kept", key, KEY1);
    bus_write(ADDR_MSG, 32'h66666666);
    chk("b2_run_drop", message, MSG2);
    chk("b2_start_single", 128'(core_start), 128'h0);
    for (int i = 0; i < 62; i++) tick();
    chk("to_busy_before", 128'(bif.busy), 128'd1);
    chk("to_err_before", 128'(bif.err), 128'h0);
    tick();
    chk("to_err", 128'(bif.err), 128'd1);
    chk("to_busy", 128'(bif.busy), 128'h0);
    core_done = 1'b1; crypte = CT3;
    tick();
    core_done = 1'b0;
    chk("to_done_ignored_busy", 128'(bif.busy), 128'h0);
    chk("to_err_sticky", 128'(bif.err), 128'd1);
    bus_read("to_load_rd", 32'h0);

    // Block 3: rewrite message, successful done clears err
    for (int i = 0; i < NWORDS; i++) bus_write(ADDR_MSG, 32'ha0a0a0a0 + 32'(i));
    tick();
    chk("b3_start", 128'(core_start), 128'd1);
    chk("b3_err_held", 128'(bif.err), 128'd1);
    core_done = 1'b1; crypte = CT3;
    tick();
    core_done = 1'b0; crypte = '0;
    chk("b3_err_clr", 128'(bif.err), 128'h0);
    read_block("b3_rd", CT3);

    // Reset mid-RUN
    for (int i = 0; i < NWORDS; i++) bus_write(ADDR_MSG, 32'hd0d0d0d0 + 32'(i));
    tick();
    chk("rr_busy", 128'(bif.busy), 128'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("rr_message", message, 128'h0);
    chk("rr_key", key, 128'h0);
    chk("rr_rdata", 128'(bif.rdata), 128'h0);
    chk("rr_flags", {bif.rvalid, bif.busy, bif.err, core_start}, 128'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    core_done = 1'b1; crypte = CT1;
    tick();
    core_done = 1'b0;
    chk("rr_done_ignored", {bif.busy, bif.err, core_start}, 128'h0);
    bus_read("rr_rd", 32'h0);

    // Five message words with no key: fifth restarts word 0
    bus_write(ADDR_MSG, 32'ha1a1a1a1);
    bus_write(ADDR_MSG, 32'ha2a2a2a2);
    bus_write(ADDR_MSG, 32'ha3a3a3a3);
    bus_write(ADDR_MSG, 32'ha4a4a4a4);
    bus_write(ADDR_MSG, 32'ha5a5a5a5);
    chk("wrap_message", message, 128'ha5a5a5a5_a2a2a2a2_a3a3a3a3_a4a4a4a4);
    tick();
    chk("wrap_no_start", {core_start, bif.busy}, 128'h0);
    chk("wrap_key", key, 128'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
